// File: rtl/piezo_tune_seq.sv
// piezo_tune_seq: plays one of three fixed tunes (fanfare, calibration chime,
// error beep) on a differential piezo pair. It is started by a go/tune request
// and reports busy/done back. It supports a level abort and optional pre-emption.
// All outputs are registered from the next-state values, so the first note is
// visible (busy=1, piezo=1) one edge after go is sampled.
module piezo_tune_seq #(
  parameter int CLK_FREQ  = 50000000,
  parameter bit FAST_SIM  = 1'b0,
  parameter bit PREEMPT   = 1'b0,
  // Right shift applied to every note duration when FAST_SIM=1. The default
  // of 4 divides each duration by 16; a simulation may shorten notes further.
  parameter int SIM_SHIFT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       go,
  input  logic [1:0] tune,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic [2:0] note_idx,
  output logic       piezo,
  output logic       piezo_n
);

  localparam int PW    = $clog2(CLK_FREQ / 1000) + 1;
  localparam int DW    = 26;
  localparam int SHIFT = FAST_SIM ? SIM_SHIFT : 0;

  // Tone half-period source: full period in clocks, floor division
  localparam logic [PW-1:0] P_G6 = PW'(CLK_FREQ / 1568);
  localparam logic [PW-1:0] P_C7 = PW'(CLK_FREQ / 2093);
  localparam logic [PW-1:0] P_E7 = PW'(CLK_FREQ / 2637);
  localparam logic [PW-1:0] P_G7 = PW'(CLK_FREQ / 3136);
  localparam logic [PW-1:0] P_REST = '0;

  // Note durations in clocks
  localparam logic [DW-1:0] D22    = DW'((1 << 22) >> SHIFT);
  localparam logic [DW-1:0] D23    = DW'((1 << 23) >> SHIFT);
  localparam logic [DW-1:0] D23P22 = DW'(((1 << 23) + (1 << 22)) >> SHIFT);
  localparam logic [DW-1:0] D25    = DW'((1 << 25) >> SHIFT);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DONE} state_t;

  state_t         state, state_next;
  logic [1:0]     tune_reg, tune_next;
  logic [2:0]     note_next;
  logic [DW-1:0]  dur_cnt, dur_next;
  logic [PW-1:0]  per_cnt, per_next;
  logic [PW-1:0]  cur_per, next_per;
  logic [DW-1:0]  cur_dur;
  logic [2:0]     cur_last;
  logic           start;
  logic           tone_next;
  logic           piezo_next;

  // Tone period for a note; zero marks a rest
  function automatic logic [PW-1:0] note_period(input logic [1:0] t, input logic [2:0] i);
    logic [PW-1:0] p;
    p = P_REST;
    case (t)
      2'd0: begin
        case (i)
          3'd0:    p = P_G6;
          3'd1:    p = P_C7;
          3'd2:    p = P_E7;
          3'd3:    p = P_G7;
          3'd4:    p = P_E7;
          default: p = P_G7;
        endcase
      end
      2'd1: begin
        case (i)
          3'd0:    p = P_C7;
          3'd1:    p = P_E7;
          default: p = P_G7;
        endcase
      end
      2'd2: begin
        p = (i == 3'd1) ? P_REST : P_G6;
      end
      default: p = P_REST;
    endcase
    return p;
  endfunction

  // Duration of a note in clocks
  function automatic logic [DW-1:0] note_duration(input logic [1:0] t, input logic [2:0] i);
    logic [DW-1:0] d;
    d = D22;
    case (t)
      2'd0: begin
        case (i)
          3'd0, 3'd1, 3'd2: d = D23;
          3'd3:             d = D23P22;
          3'd4:             d = D22;
          default:          d = D25;
        endcase
      end
      2'd1:    d = D22;
      2'd2:    d = (i == 3'd1) ? D22 : D23;
      default: d = D22;
    endcase
    return d;
  endfunction

  assign cur_per  = note_period(tune_reg, note_idx);
  assign cur_dur  = note_duration(tune_reg, note_idx);
  assign cur_last = (tune_reg == 2'd0) ? 3'd5 : 3'd2;
  assign start    = go && (tune != 2'd3);

  // Next-state logic: note sequencing, duration and period counters
  always_comb begin
    state_next = state;
    tune_next  = tune_reg;
    note_next  = note_idx;
    dur_next   = dur_cnt;
    per_next   = per_cnt;
    case (state)
      S_IDLE: begin
        if (!abort && start) begin
          state_next = S_PLAY;
          tune_next  = tune;
          note_next  = 3'd0;
          dur_next   = '0;
          per_next   = '0;
        end
      end
      S_PLAY: begin
        if (abort) begin
          state_next = S_IDLE;
          note_next  = 3'd0;
          dur_next   = '0;
          per_next   = '0;
        end else if (PREEMPT && start) begin
          tune_next = tune;
          note_next = 3'd0;
          dur_next  = '0;
          per_next  = '0;
        end else if (dur_cnt == cur_dur - DW'(1)) begin
          dur_next = '0;
          per_next = '0;
          if (note_idx == cur_last) begin
            state_next = S_DONE;
            note_next  = 3'd0;
          end else begin
            note_next = note_idx + 3'd1;
          end
        end else begin
          dur_next = dur_cnt + DW'(1);
          if (cur_per != '0) begin
            per_next = (per_cnt == cur_per - PW'(1)) ? '0 : per_cnt + PW'(1);
          end
        end
      end
      default: begin
        // DONE lasts one cycle; a go seen here starts the next tune directly
        if (!abort && start) begin
          state_next = S_PLAY;
          tune_next  = tune;
          note_next  = 3'd0;
          dur_next   = '0;
          per_next   = '0;
        end else begin
          state_next = S_IDLE;
        end
      end
    endcase
  end

  // Square-wave level for the upcoming cycle; rests and non-PLAY states are silent
  always_comb begin
    next_per   = note_period(tune_next, note_next);
    tone_next  = (state_next == S_PLAY) && (next_per != '0);
    piezo_next = tone_next && (per_next < (next_per >> 1));
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      tune_reg <= 2'd0;
      note_idx <= 3'd0;
      dur_cnt  <= '0;
      per_cnt  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      piezo    <= 1'b0;
      piezo_n  <= 1'b0;
    end else begin
      state    <= state_next;
      tune_reg <= tune_next;
      note_idx <= note_next;
      dur_cnt  <= dur_next;
      per_cnt  <= per_next;
      busy     <= (state_next == S_PLAY);
      done     <= (state_next == S_DONE);
      piezo    <= piezo_next;
      piezo_n  <= tone_next && !piezo_next;
    end
  end

endmodule

// File: tb/tb_piezo_tune_seq.sv
// Testbench for piezo_tune_seq: two instances (PREEMPT=0 and PREEMPT=1) share
// the same stimulus. Note durations are shortened with SIM_SHIFT=14 and a
// 200 kHz clock parameter keeps the tone periods short.
// Expected tune outcomes are queued when a tune is requested and checked when
// each instance ends a busy period.
module tb_piezo_tune_seq;

  localparam int CLK_HZ = 200000;
  localparam int SHIFT  = 14;
  localparam int D22    = (1 << 22) >> SHIFT;
  localparam int D23    = (1 << 23) >> SHIFT;
  localparam int D23P22 = ((1 << 23) + (1 << 22)) >> SHIFT;
  localparam int D25    = (1 << 25) >> SHIFT;
  localparam int FANFARE_LEN = 3 * D23 + D23P22 + D22 + D25;
  localparam int CHIME_LEN   = 3 * D22;
  localparam int ERROR_LEN   = D23 + D22 + D23;
  localparam int P_G6        = CLK_HZ / 1568;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       go = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] tune = 2'd0;

  logic       busy0, done0, piezo0, piezo_n0;
  logic [2:0] note0;
  logic       busy1, done1, piezo1, piezo_n1;
  logic [2:0] note1;

  always #5 clk = ~clk;

  piezo_tune_seq #(.CLK_FREQ(CLK_HZ), .FAST_SIM(1'b1), .PREEMPT(1'b0), .SIM_SHIFT(SHIFT)) dut0 (
    .clk(clk), .rst_n(rst_n), .go(go), .tune(tune), .abort(abort),
    .busy(busy0), .done(done0), .note_idx(note0), .piezo(piezo0), .piezo_n(piezo_n0)
  );

  piezo_tune_seq #(.CLK_FREQ(CLK_HZ), .FAST_SIM(1'b1), .PREEMPT(1'b1), .SIM_SHIFT(SHIFT)) dut1 (
    .clk(clk), .rst_n(rst_n), .go(go), .tune(tune), .abort(abort),
    .busy(busy1), .done(done1), .note_idx(note1), .piezo(piezo1), .piezo_n(piezo_n1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  typedef struct {
    int cycles;
    int done;
    int last;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   cnt[2];
  bit   prev[2];
  int   last_note[2];
  int   done_cnt[2];

  task automatic push_both(input int cyc0, input int dn0, input int last0,
                           input int cyc1, input int dn1, input int last1);
    exp_t e;
    e.cycles = cyc0; e.done = dn0; e.last = last0;
    q0.push_back(e);
    e.cycles = cyc1; e.done = dn1; e.last = last1;
    q1.push_back(e);
  endtask

  // Per-instance monitor step, called once per falling edge
  task automatic mon_step(input int id, input logic b, input logic d, input logic [2:0] n,
                          input logic pz, input logic pzn);
    exp_t e;
    bit   have;
    if (d) done_cnt[id]++;
    if (b) begin
      if (!prev[id]) cnt[id] = 0;
      cnt[id]++;
      last_note[id] = int'(n);
    end else if (prev[id]) begin
      have = 1'b0;
      if (id == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      if (id == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      if (!have) begin
        check_eq($sformatf("dut%0d_unexpected_end", id), 32'd1, 32'd0);
      end else begin
        $display("dut%0d tune end: busy_cycles=%0d done=%0d last_note=%0d", id, cnt[id], d, last_note[id]);
        check_eq($sformatf("dut%0d_busy_cycles", id), cnt[id], e.cycles);
        check_eq($sformatf("dut%0d_done_at_end", id), {31'd0, d}, e.done);
        check_eq($sformatf("dut%0d_last_note", id), last_note[id], e.last);
        check_eq($sformatf("dut%0d_silent_after", id), {30'd0, pz, pzn}, 32'd0);
      end
    end
    prev[id] = b;
  endtask

  // Monitor: tracks busy periods of both instances; reset clears tracking
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        prev[i] = 1'b0;
        cnt[i]  = 0;
      end
    end else begin
      mon_step(0, busy0, done0, note0, piezo0, piezo_n0);
      mon_step(1, busy1, done1, note1, piezo1, piezo_n1);
    end
  end

  task automatic start_tune(input logic [1:0] t);
    @(negedge clk);
    go   = 1'b1;
    tune = t;
    @(negedge clk);
    go   = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int k;
    k = 0;
    while ((busy0 || busy1) && k < limit) begin
      @(negedge clk);
      k++;
    end
    check_eq("idle_within_budget", {31'd0, busy0 | busy1}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int mis;
    int comp;
    int k;
    for (int i = 0; i < 2; i++) begin
      prev[i] = 1'b0; cnt[i] = 0; last_note[i] = 0; done_cnt[i] = 0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("reset_busy", {31'd0, busy0}, 32'd0);
    check_eq("reset_done", {31'd0, done0}, 32'd0);
    check_eq("reset_note", {29'd0, note0}, 32'd0);
    check_eq("reset_piezo", {30'd0, piezo0, piezo_n0}, 32'd0);
    check_eq("reset_busy1", {31'd0, busy1}, 32'd0);
    rst_n = 1'b1;

    // Fanfare: full length, and the G6 square wave on note 0
    push_both(FANFARE_LEN, 1, 5, FANFARE_LEN, 1, 5);
    start_tune(2'd0);
    check_eq("fanfare_first_note", {29'd0, note0}, 32'd0);
    mis = 0;
    comp = 0;
    for (int i = 0; i < P_G6; i++) begin
      if (piezo0 !== ((i < P_G6 / 2) ? 1'b1 : 1'b0)) mis++;
      if (piezo_n0 !== ~piezo0) comp++;
      @(negedge clk);
    end
    check_eq("g6_wave_shape", mis, 0);
    check_eq("g6_complement", comp, 0);
    check_eq("g6_period_wrap", {31'd0, piezo0}, 32'd1);
    wait_idle(FANFARE_LEN + 100);

    // Error beep: tone, rest, tone
    push_both(ERROR_LEN, 1, 2, ERROR_LEN, 1, 2);
    start_tune(2'd2);
    repeat (599) @(negedge clk);
    check_eq("error_rest_note", {29'd0, note0}, 32'd1);
    check_eq("error_rest_silent", {30'd0, piezo0, piezo_n0}, 32'd0);
    repeat (169) @(negedge clk);
    check_eq("error_third_note", {29'd0, note0}, 32'd2);
    check_eq("error_third_high", {30'd0, piezo0, piezo_n0}, 32'd2);
    wait_idle(ERROR_LEN + 100);

    // Abort during the chime: immediate stop, no done pulse
    push_both(101, 0, 0, 101, 0, 0);
    start_tune(2'd1);
    repeat (100) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("abort_busy", {31'd0, busy0}, 32'd0);
    check_eq("abort_note", {29'd0, note0}, 32'd0);
    check_eq("abort_silent", {30'd0, piezo0, piezo_n0}, 32'd0);
    wait_idle(10);

    // go while busy: ignored without pre-emption, restarts with it
    push_both(CHIME_LEN, 1, 2, 301 + ERROR_LEN, 1, 2);
    start_tune(2'd1);
    repeat (300) @(negedge clk);
    go   = 1'b1;
    tune = 2'd2;
    @(negedge clk);
    go   = 1'b0;
    check_eq("nopreempt_note", {29'd0, note0}, 32'd1);
    check_eq("preempt_note", {29'd0, note1}, 32'd0);
    check_eq("preempt_piezo_high", {31'd0, piezo1}, 32'd1);
    wait_idle(ERROR_LEN + 400);

    // go during the DONE cycle starts the next tune straight away
    push_both(CHIME_LEN, 1, 2, CHIME_LEN, 1, 2);
    push_both(ERROR_LEN, 1, 2, ERROR_LEN, 1, 2);
    start_tune(2'd1);
    k = 0;
    while (!done0 && k < CHIME_LEN + 50) begin
      @(negedge clk);
      k++;
    end
    check_eq("done_seen", {31'd0, done0}, 32'd1);
    go   = 1'b1;
    tune = 2'd2;
    @(negedge clk);
    go   = 1'b0;
    check_eq("go_in_done_busy", {31'd0, busy0}, 32'd1);
    check_eq("go_in_done_note", {29'd0, note0}, 32'd0);
    wait_idle(ERROR_LEN + 100);

    // Reserved tune is ignored
    start_tune(2'd3);
    repeat (5) @(negedge clk);
    check_eq("tune3_busy", {30'd0, busy0, busy1}, 32'd0);
    check_eq("tune3_silent", {30'd0, piezo0, piezo_n0}, 32'd0);

    // Asynchronous reset mid-tune clears outputs before the next clock edge
    start_tune(2'd0);
    repeat (50) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_busy", {30'd0, busy0, busy1}, 32'd0);
    check_eq("async_rst_note", {29'd0, note0}, 32'd0);
    check_eq("async_rst_piezo", {28'd0, piezo0, piezo_n0, piezo1, piezo_n1}, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("post_rst_busy", {31'd0, busy0}, 32'd0);

    // Totals: one done per normally completed tune
    check_eq("dut0_done_pulses", done_cnt[0], 5);
    check_eq("dut1_done_pulses", done_cnt[1], 5);
    check_eq("queues_drained", q0.size() + q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
